// File: rtl/iob_cache_be_mem_model_if.sv
// IOb native request/response bundle for the back-end memory model.
// Signal suffixes are from the memory (slave) point of view.
interface iob_cache_be_mem_model_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16
);
  logic                  valid_i;
  logic [ADDR_W-1:0]     addr_i;
  logic [DATA_W-1:0]     wdata_i;
  logic [DATA_W/8-1:0]   wstrb_i;
  logic [DATA_W-1:0]     rdata_o;
  logic                  rvalid_o;
  logic                  ready_o;

  modport master (
    output valid_i, addr_i, wdata_i, wstrb_i,
    input  rdata_o, rvalid_o, ready_o
  );

  modport slave (
    input  valid_i, addr_i, wdata_i, wstrb_i,
    output rdata_o, rvalid_o, ready_o
  );
endinterface

// File: rtl/iob_cache_be_mem_model.sv
// Back-end memory model: byte-strobed writes, RD_LAT-deep pipelined reads, periodic ready drop.
// Optional access/stall counters are built when IOB_CACHE_BE_MEM_STATS_EN is defined.
module iob_cache_be_mem_model #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned READY_PERIOD = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef IOB_CACHE_BE_MEM_STATS_EN
  input  logic        clr_stats_i,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o,
  output logic [31:0] stall_cnt_o,
`endif
  iob_cache_be_mem_model_if.slave bus
);

  localparam int unsigned NBytes   = DATA_W / 8;
  localparam int unsigned NBYTES_W = $clog2(NBytes);
  localparam int unsigned WordW    = ADDR_W - NBYTES_W;
  localparam int unsigned Depth    = 2 ** WordW;
  localparam int unsigned CntW     = (READY_PERIOD > 2) ? $clog2(READY_PERIOD) : 1;

  if (RD_LAT < 1 || RD_LAT > 16) begin : g_bad_lat
    $error("RD_LAT must be in 1..16");
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of 8");
  end

  logic [DATA_W-1:0] mem_q [Depth];
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              at_wrap, ready;
  logic              acc, rd_acc, wr_acc;
  logic [WordW-1:0]  widx;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0] pdata_q [RD_LAT];
  logic [DATA_W-1:0] pdata_d [RD_LAT];

  // Throttle counter free-runs; ready drops in its last slot only.
  always_comb begin
    at_wrap = (READY_PERIOD >= 2) && (cnt_q == CntW'(READY_PERIOD - 1));
    ready   = ~at_wrap;
    cnt_d   = (at_wrap || READY_PERIOD < 2) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign widx   = bus.addr_i[ADDR_W-1:NBYTES_W];
  assign acc    = bus.valid_i & ready & ~rst_i;
  assign wr_acc = acc & (|bus.wstrb_i);
  assign rd_acc = acc & ~(|bus.wstrb_i);

  // Memory is deliberately left out of reset so contents survive a mid-run reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      for (int b = 0; b < int'(NBytes); b++) begin
        if (bus.wstrb_i[b]) begin
          mem_q[widx][b*8 +: 8] <= bus.wdata_i[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    vld_d[0]   = rd_acc;
    pdata_d[0] = mem_q[widx];
    for (int i = 1; i < int'(RD_LAT); i++) begin
      vld_d[i]   = vld_q[i-1];
      pdata_d[i] = pdata_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Data stages need no reset: rdata_o is masked by the valid stage.
  always_ff @(posedge clk_i) begin
    pdata_q <= pdata_d;
  end

  assign bus.ready_o  = ready;
  assign bus.rvalid_o = vld_q[RD_LAT-1];
  assign bus.rdata_o  = vld_q[RD_LAT-1] ? pdata_q[RD_LAT-1] : '0;

`ifdef IOB_CACHE_BE_MEM_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall = bus.valid_i & ~ready;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_stats_i) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (rd_acc && rd_cnt_q != '1)       rd_cnt_q    <= rd_cnt_q + 32'd1;
      if (wr_acc && wr_cnt_q != '1)       wr_cnt_q    <= wr_cnt_q + 32'd1;
      if (stall && stall_cnt_q != '1)     stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
